// File: rtl/bram_uart_dumper.sv
// Reads a run of words from a synchronous BRAM and sends each one out as an 8N1 UART frame.
// The address wraps modulo the RAM depth, and the dump length is clamped to the RAM depth.
module bram_uart_dumper #(
    parameter int unsigned p_BAUDRATE  = 10_000,
    parameter int unsigned p_CLK_FREQ  = 1_000_000,
    parameter int unsigned p_RAM_DEPTH = 4,
    localparam int unsigned AW = (p_RAM_DEPTH > 1) ? $clog2(p_RAM_DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic [AW-1:0] iN_addr,
    input  logic [AW:0]   iN_len,
    output logic [AW-1:0] oN_bram_addr,
    input  logic [7:0]    i8_bram_data,
    output logic          o_uart_tx,
    output logic          o_busy,
    output logic          o_done
);

    localparam int unsigned CPB = p_CLK_FREQ / p_BAUDRATE;
    localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [AW:0]   DEPTH_LEN = (AW + 1)'(p_RAM_DEPTH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(p_RAM_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLatch,
        StStart,
        StData,
        StStop,
        StNext
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          done_q, done_d;

    logic [AW:0]   len_clamp;
    logic [AW-1:0] addr_start;
    logic          baud_tick;

    assign len_clamp  = (iN_len > DEPTH_LEN) ? DEPTH_LEN : iN_len;
    // An out-of-range start address (non power-of-two depth) is folded back to 0.
    assign addr_start = (iN_addr > ADDR_LAST) ? '0 : iN_addr;
    assign baud_tick  = (cnt_q == CPB_LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    addr_d  = addr_start;
                    len_d   = len_clamp;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = (len_clamp == '0) ? StNext : StAddr;
                end
            end
            StAddr: begin
                state_d = StLatch;
            end
            StLatch: begin
                // BRAM output now reflects the address presented during StAddr.
                shreg_d = i8_bram_data;
                cnt_d   = '0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    len_d   = len_q - 1'b1;
                    state_d = StNext;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StNext: begin
                if (len_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                    state_d = StAddr;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The done pulse is registered so it lands on the first idle cycle, the same cycle busy drops.
    assign o_done       = done_q;
    assign o_busy       = (state_q != StIdle);
    assign oN_bram_addr = addr_q;
    assign o_uart_tx    = (state_q == StStart) ? 1'b0 :
                          (state_q == StData)  ? shreg_q[0] : 1'b1;

endmodule
